// File: rtl/s4ga_frame.sv
// s4ga_frame: streamed-LUT fabric core. It accepts one configuration segment per
// valid cycle and evaluates N K-input LUTs in stream order. Each LUT writes either
// immediately or at the frame boundary. External inputs are snapshotted once per
// frame, so they stay constant while a frame is being evaluated.
module s4ga_frame #(
    parameter int N    = 16,
    parameter int K    = 4,
    parameter int SI_W = 4,
    parameter int I    = 4,
    parameter int O    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SI_W-1:0]           si,
    input  logic                      si_valid,
    input  logic [(I > 0 ? I : 1)-1:0] ext_in,
    output logic [O-1:0]              out,
    output logic                      frame_done,
    output logic [$clog2(N)-1:0]      lut_n
);

    localparam int IDX_W     = $clog2(N + I);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_BITS = 1 << K;
    localparam int MASK_SEGS = (MASK_BITS + SI_W - 1) / SI_W;
    localparam int ACC_W     = IDX_SEGS * SI_W;
    localparam int MASK_W    = MASK_SEGS * SI_W;
    localparam int EXT_W     = (I > 0) ? I : 1;
    localparam int MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SC_W      = $clog2(MAX_SEGS + 1);
    localparam int KC_W      = $clog2(K + 1);
    localparam int LN_W      = $clog2(N);

    typedef enum logic [1:0] {S_IDX, S_MASK, S_MODE} state_t;

    state_t            state, state_nx;
    logic [KC_W-1:0]   k_cnt, k_nx;
    logic [SC_W-1:0]   seg_cnt, seg_nx;
    logic              idx_last;

    logic [N-1:0]      val, pend, pend_v;
    logic [EXT_W-1:0]  ext_snap;
    logic [ACC_W-1:0]  acc, acc_nx;
    logic [MASK_W-1:0] mask_sr;
    logic [K-1:0]      in_reg;
    logic [IDX_W-1:0]  idx_field;
    logic              res;
    logic [MASK_BITS-1:0] mask_bits;
    logic              lut_r;
    logic              last_lut;

    assign out = val[O-1:0];

    // Record sequencer: state and counters advance only on accepted segments
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDX;
            k_cnt   <= '0;
            seg_cnt <= '0;
        end else if (si_valid) begin
            state   <= state_nx;
            k_cnt   <= k_nx;
            seg_cnt <= seg_nx;
        end
    end

    // Next position within the per-LUT record, assuming this cycle's segment is accepted
    always_comb begin
        state_nx = state;
        k_nx     = k_cnt;
        seg_nx   = seg_cnt;
        idx_last = 1'b0;
        case (state)
            S_IDX: begin
                if (seg_cnt == SC_W'(IDX_SEGS - 1)) begin
                    idx_last = 1'b1;
                    seg_nx   = '0;
                    if (k_cnt == KC_W'(K - 1)) begin
                        k_nx     = '0;
                        state_nx = S_MASK;
                    end else begin
                        k_nx = k_cnt + 1'b1;
                    end
                end else begin
                    seg_nx = seg_cnt + 1'b1;
                end
            end
            S_MASK: begin
                if (seg_cnt == SC_W'(MASK_SEGS - 1)) begin
                    seg_nx   = '0;
                    state_nx = S_MODE;
                end else begin
                    seg_nx = seg_cnt + 1'b1;
                end
            end
            S_MODE:  state_nx = S_IDX;
            default: state_nx = S_IDX;
        endcase
    end

    // Index resolve: LUT value, snapped external input, or 0 when out of range
    always_comb begin
        acc_nx    = ACC_W'({acc, si});
        idx_field = acc_nx[IDX_W-1:0];
        res       = 1'b0;
        for (int i = 0; i < N; i++)
            if (32'(idx_field) == i) res = val[i];
        for (int i = 0; i < I; i++)
            if (32'(idx_field) == N + i) res = ext_snap[i];
        mask_bits = mask_sr[MASK_BITS-1:0];
        lut_r     = mask_bits[in_reg];
        last_lut  = (lut_n == LN_W'(N - 1));
    end

    // Field capture, LUT evaluation, pending commits and frame boundary handling
    always_ff @(posedge clk) begin
        if (rst) begin
            val        <= '0;
            pend       <= '0;
            pend_v     <= '0;
            ext_snap   <= ext_in;
            lut_n      <= '0;
            frame_done <= 1'b0;
            acc        <= '0;
            mask_sr    <= '0;
            in_reg     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (si_valid) begin
                case (state)
                    S_IDX: begin
                        acc <= acc_nx;
                        if (idx_last)
                            for (int j = 0; j < K; j++)
                                if (k_cnt == KC_W'(j)) in_reg[j] <= res;
                    end
                    S_MASK: mask_sr <= MASK_W'({mask_sr, si});
                    S_MODE: begin
                        if (last_lut) begin
                            // Pending commits first; the last LUT's own write (index N-1) wins
                            for (int i = 0; i < N; i++)
                                if (pend_v[i]) val[i] <= pend[i];
                            pend_v         <= '0;
                            val[lut_n]     <= lut_r;
                            ext_snap       <= ext_in;
                            frame_done     <= 1'b1;
                            lut_n          <= '0;
                        end else begin
                            if (si[0]) begin
                                pend[lut_n]   <= lut_r;
                                pend_v[lut_n] <= 1'b1;
                            end else begin
                                val[lut_n] <= lut_r;
                            end
                            lut_n <= lut_n + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/s4ga_frame.md
Name: s4ga_frame

Overview:
- Second-generation streamed-LUT fabric core for the s4ga family.
- Receives a stream of per-LUT configuration segments and evaluates N K-input LUTs in order.
- Adds over the first generation:
  - LUT-number-addressed state array, in place of a shift register.
  - External primary inputs selectable as LUT inputs.
  - Per-LUT registered (frame-synchronous) or combinational (immediate) update mode.
  - Input stall handshake and a frame-boundary strobe.
- Sits between the tile's config-stream pins and its user I/O.

Parameters:
- N, 16: number of LUTs, ≥2.
- K, 4: LUT inputs, 1..6.
- SI_W, 4: config segment width in bits.
- I, 4: number of external inputs, ≥0.
- O, 8: number of exported LUT outputs, 1..N.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- si  in  SI_W  config segment.
- si_valid  in  1  segment on si is consumed this cycle when high.
- ext_in  in  I  external inputs.
- out  out  O  val[O-1:0], current LUT values 0..O-1.
- frame_done  out  1  one-cycle pulse, frame completed.
- lut_n  out  clog2(N)  index of the LUT currently being loaded.

Behaviour:
- Widths:
  - IDX_W = clog2(N+I).
  - IDX_SEGS = ceil(IDX_W/SI_W).
  - MASK_SEGS = ceil(2^K/SI_W).
- Per-LUT record, in stream order:
  - K index fields of IDX_SEGS segments each.
  - Mask of MASK_SEGS segments.
  - One mode segment.
  - Total SEGS = K*IDX_SEGS + MASK_SEGS + 1 accepted segments.
- Multi-segment fields arrive most-significant segment first. Excess high bits are padding and are ignored.
- Segments advance only on cycles with si_valid=1. With si_valid=0, all state holds except ext_snap as noted below.
- FSM: IDX(k, seg) -> MASK(seg) -> MODE -> IDX(0, 0) of the next LUT.
  - lut_n wraps N-1 -> 0.
- Index resolve, on acceptance of the final segment of index field j:
  - idx < N: in[j] = val[idx].
  - N ≤ idx < N+I: in[j] = ext_snap[idx-N].
  - Otherwise: in[j] = 0.
  - in[j] is captured into an input register.
- LUT result r = mask[a], where a = {in[K-1], …, in[0]}; field j=0 is the LSB.
- Mode segment bit0 = FF; other bits are reserved and ignored.
  - FF=0 (immediate): val[lut_n] <= r on the mode-segment acceptance edge. Visible on out the next cycle. Later LUTs in the same frame see the new value.
  - FF=1 (registered): pend[lut_n] <= r and pend_v[lut_n] <= 1. val is unchanged until frame end.
- Frame end, on acceptance of LUT N-1's mode segment:
  - For every LUT with pend_v set: val <= pend, and pend_v is cleared.
  - If LUT N-1 is itself FF: its r goes directly to val on that same edge.
  - If LUT N-1 is immediate: its write and the commits land on the same edge. The indices are distinct, so there is no conflict.
  - frame_done = 1 on the following cycle only.
  - ext_snap <= ext_in.
- ext_snap loads ext_in every cycle that rst=1, and at each frame end. It is constant within a frame.
- Reset values: val=0, pend=0, pend_v=0, FSM at IDX(0,0), lut_n=0, out=0, frame_done=0.
- Reset mid-frame aborts the partial record and any pending FF results. The stream restarts at LUT 0.
- rst has priority over si_valid.

Test Plan:
- Reset: hold rst 3 cycles with si_valid=1 and random si, then release -> out=0, frame_done=0, lut_n=0. Defaults give SEGS=13.
- Immediate ext passthrough: ext_in=4'b0001; LUT0 indices all 16 (ext0), mask 0xAAAA, mode 0 -> out[0]=1 on the cycle after LUT0's 13th segment; LUTs 1..15 mask 0 -> out stays 8'h01 and frame_done pulses after segment 208.
- Registered toggle: LUT0 index 0 ×4, mask 0x5555, FF=1; other LUTs zero -> out[0] stays 0 during frame 1, reads 1 after the frame-1 boundary, 0 after frame 2; frame_done pulses every 208 accepted segments.
- Stall: same stream as the ext passthrough case with si_valid deasserted on alternate cycles -> identical out sequence per accepted segment; out[0]=1 after 26 clocks; lut_n frozen during gaps.
- Chain plus out-of-range index:
  - LUT1 = immediate buffer of LUT0 (index 0, mask 0xAAAA) -> LUT1 updates in the same frame as LUT0.
  - LUT2 index 31 (IDX_W=5, ≥N+I) with mask 0xAAAA -> out[2]=0 regardless of ext_in.
- Reset mid-frame: assert rst during LUT5's mask segments with LUT0 FF pending 1 -> after release out=0, lut_n=0, and the pending value is never committed.
